// File: rtl/jacobi_pkg.sv
// jacobi_pkg: shared defaults, counter width and FSM encoding for the Jacobi sweep controller
package jacobi_pkg;
   localparam int N_DEF          = 32;
   localparam int IDXW_DEF       = 5;
   localparam int MAX_SWEEPS_DEF = 16;
   localparam int SWEEP_W        = 5;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_ISSUE     = 3'd1;
   localparam state_t S_WAIT      = 3'd2;
   localparam state_t S_SWEEP_END = 3'd3;
   localparam state_t S_FINISH    = 3'd4;
endpackage

// File: rtl/jacobi_sweep_ctrl_if.sv
// jacobi_sweep_ctrl_if: pivot handshake between sweep controller and rotation datapath
interface jacobi_sweep_ctrl_if #(parameter int IDXW = jacobi_pkg::IDXW_DEF);
   logic            piv_valid;
   logic            piv_ready;
   logic [IDXW-1:0] piv_p;
   logic [IDXW-1:0] piv_q;
   logic            rot_done;
   logic            rot_skip;
   modport master (output piv_valid, piv_p, piv_q, input piv_ready, rot_done, rot_skip);
   modport slave  (input piv_valid, piv_p, piv_q, output piv_ready, rot_done, rot_skip);
endinterface

// File: rtl/jacobi_pair_gen.sv
// jacobi_pair_gen: cyclic-by-row (p,q) pivot walker over the strict upper triangle
module jacobi_pair_gen
   import jacobi_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int IDXW = IDXW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            adv,
   output logic [IDXW-1:0] p,
   output logic [IDXW-1:0] q,
   output logic            last
);
   localparam logic [IDXW-1:0] P_LAST = IDXW'(N - 2);
   localparam logic [IDXW-1:0] Q_LAST = IDXW'(N - 1);
   assign last = (p == P_LAST) && (q == Q_LAST);
   // On the last pair an advance is a no-op; the controller leaves the sweep instead
   always_ff @(posedge clk) begin
      if (reset) begin
         p <= '0;
         q <= '0;
      end else if (load) begin
         p <= '0;
         q <= IDXW'(1);
      end else if (adv && q < Q_LAST) begin
         q <= q + IDXW'(1);
      end else if (adv && p < P_LAST) begin
         p <= p + IDXW'(1);
         q <= p + IDXW'(2);
      end
   end
endmodule

// File: rtl/jacobi_sweep_ctrl.sv
// jacobi_sweep_ctrl: issues Jacobi pivot pairs sweep by sweep until all skip or the sweep limit
module jacobi_sweep_ctrl
   import jacobi_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int IDXW       = IDXW_DEF,
   parameter int MAX_SWEEPS = MAX_SWEEPS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   jacobi_sweep_ctrl_if.master pv,
   output logic [SWEEP_W-1:0] sweep_cnt,
   output logic               busy,
   output logic               done,
   output logic               converged
);
   state_t             state;
   logic               all_skip;
   logic               load;
   logic               adv;
   logic               last;
   logic [SWEEP_W-1:0] cnt_nxt;
   assign cnt_nxt = sweep_cnt + SWEEP_W'(1);
   // Reload the walker on a fresh start or when another sweep is needed
   assign load = (state == S_IDLE && start) ||
                 (state == S_SWEEP_END && !all_skip && cnt_nxt != SWEEP_W'(MAX_SWEEPS));
   assign adv          = (state == S_WAIT) && pv.rot_done;
   assign pv.piv_valid = (state == S_ISSUE);
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_FINISH);
   jacobi_pair_gen #(.N(N), .IDXW(IDXW)) u_pair_gen (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .adv   (adv),
      .p     (pv.piv_p),
      .q     (pv.piv_q),
      .last  (last)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         sweep_cnt <= '0;
         all_skip  <= 1'b1;
         converged <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state     <= S_ISSUE;
               sweep_cnt <= '0;
               all_skip  <= 1'b1;
               converged <= 1'b0;
            end
            S_ISSUE: if (pv.piv_ready) state <= S_WAIT;
            S_WAIT: if (pv.rot_done) begin
               all_skip <= all_skip & pv.rot_skip;
               state    <= last ? S_SWEEP_END : S_ISSUE;
            end
            S_SWEEP_END: begin
               sweep_cnt <= cnt_nxt;
               converged <= all_skip;
               state     <= load ? S_ISSUE : S_FINISH;
               if (load) all_skip <= 1'b1;
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end
endmodule
